// File: rtl/bcd_pkg.sv
// Shared widths, digit limits and the single-digit BCD step function used by
// the cascadable BCD counter.
package bcd_pkg;

    localparam int          DIG_W   = 4;
    localparam int          DEC_W   = 10;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef struct packed {
        logic [DIG_W-1:0] digit;
        logic             flag;   // carry (up) or borrow (down) out of this digit
    } step_t;

    // Invalid codes collapse to 0 (up) or 9 (down) and never pass a flag on.
    function automatic step_t bcd_step(input logic [DIG_W-1:0] d, input logic up);
        step_t r;
        r.flag  = 1'b0;
        r.digit = d;
        if (d > BCD_MAX) begin
            r.digit = up ? 4'd0 : BCD_MAX;
        end else if (up) begin
            if (d == BCD_MAX) begin
                r.digit = 4'd0;
                r.flag  = 1'b1;
            end else begin
                r.digit = d + 4'd1;
            end
        end else begin
            if (d == 4'd0) begin
                r.digit = BCD_MAX;
                r.flag  = 1'b1;
            end else begin
                r.digit = d - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// 7442-equivalent 4-to-10 line decoder; codes 10..15 select no line.
module bcd_digit_dec
    import bcd_pkg::*;
#(
    parameter bit DEC_ACTIVE_LOW = 1'b1
) (
    input  logic [DIG_W-1:0] bcd_i,
    output logic [DEC_W-1:0] dec_o
);

    logic [DEC_W-1:0] hot;

    generate
        for (genvar gi = 0; gi < DEC_W; gi++) begin : g_line
            assign hot[gi] = (bcd_i == DIG_W'(gi));
        end
    endgenerate

    assign dec_o = DEC_ACTIVE_LOW ? ~hot : hot;

endmodule

// File: rtl/bcd_counter_dec.sv
// Multi-digit BCD up/down counter with synchronous load, ripple-enable digit
// chain and a one-of-ten decoder bank per digit.
module bcd_counter_dec
    import bcd_pkg::*;
#(
    parameter int NDIG           = 2,
    parameter bit DEC_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [DIG_W*NDIG-1:0]   load_val,
    output logic [DIG_W*NDIG-1:0]   count,
    output logic [DEC_W*NDIG-1:0]   dec,
    output logic                    tc,
    output logic                    invalid
);

    logic [DIG_W*NDIG-1:0] count_q;
    logic [DIG_W*NDIG-1:0] count_d;
    logic [DIG_W*NDIG-1:0] count_step;
    logic [NDIG:0]         ripple;
    logic [NDIG-1:0]       digit_bad;

    assign ripple[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            logic [DIG_W-1:0] cur;
            step_t            st;

            assign cur        = count_q[gi*DIG_W +: DIG_W];
            assign st         = bcd_step(cur, up);
            assign ripple[gi+1] = ripple[gi] & st.flag;
            assign count_step[gi*DIG_W +: DIG_W] = ripple[gi] ? st.digit : cur;
            assign digit_bad[gi] = (cur > BCD_MAX);

            bcd_digit_dec #(
                .DEC_ACTIVE_LOW(DEC_ACTIVE_LOW)
            ) u_dec (
                .bcd_i(cur),
                .dec_o(dec[gi*DEC_W +: DEC_W])
            );
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Carry/borrow out of the top digit is exactly the terminal-count condition.
    assign tc      = ripple[NDIG];
    assign invalid = |digit_bad;
    assign count   = count_q;

endmodule

// File: doc/bcd_counter_dec.md
Name: bcd_counter_dec

Overview:
- Parametrised multi-digit BCD up/down counter with synchronous load and enable.
- Each digit drives a 7442-style one-of-ten decoded output bank.
- Generalises our 4-input combinational decoder blocks into a sequential, cascadable counter-plus-decoder.
- Used as a decade counter / display-select source in the 74-series logic suite.

Parameters:
- NDIG, 2, number of BCD digits (1..8).
- DEC_ACTIVE_LOW, 1, decoder polarity. 1 = selected line low, others high (7442 polarity). 0 = one-hot high.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load
- load_val  input  4*NDIG  load value, digit i at bits [4i+3:4i]
- count  output  4*NDIG  registered counter value, same digit packing
- dec  output  10*NDIG  decoded lines, digit i at bits [10i+9:10i], line k = value k
- tc  output  1  terminal count: up=1 and all digits 9, or up=0 and all digits 0
- invalid  output  1  any digit holds a code in 10..15

Behaviour:
- Reset (rst_n low, asynchronous, immediate effect):
  - count = 0.
  - Every dec bank selects line 0.
  - invalid = 0.
  - tc = ~up, since tc is combinational.
- Reset release is synchronous to clk; the first update happens on the first rising edge with rst_n high.
- Priority on each rising edge: load > en > hold.
  - load=1: count <= load_val, all 16 codes per digit accepted as-is, regardless of en and up.
  - load=0, en=1: count one BCD step in direction up.
  - Otherwise: hold.
- Up step:
  - Digit 0 always steps.
  - Digit i steps only when all lower digits are 9.
  - 9 -> 0 generates a carry.
  - All-9 wraps to all-0 (e.g. 0x99 -> 0x00 for NDIG=2).
- Down step:
  - Digit i steps only when all lower digits are 0.
  - 0 -> 9 generates a borrow.
  - All-0 wraps to all-9.
- Invalid digit (10..15) selected to step:
  - Up: goes to 0 with no carry.
  - Down: goes to 9 with no borrow.
  - Invalid digits never propagate carry or borrow.
  - An invalid digit that is not selected to step holds its value.
- Latency:
  - count changes 1 cycle after the qualifying edge.
  - dec, tc and invalid are combinational from count and up; no extra latency.
- Decoder, per digit:
  - Code 0..9 asserts exactly line k.
  - Code 10..15 asserts no line: all ones when DEC_ACTIVE_LOW=1, all zeros when 0.
- tc depends on up even when en=0; it reflects the terminal condition of the held value.
- No X on any output after reset; load_val X is propagated only when load=1.

Decomposition:
- Package bcd_pkg:
  - DIG_W=4, DEC_W=10, BCD_MAX=4'd9.
  - Function bcd_step(digit, up) returning next digit plus carry/borrow flag.
- Sub-module bcd_digit_dec:
  - Pure 4-to-10 decoder with DEC_ACTIVE_LOW parameter, 7442-equivalent.
  - Generated NDIG times.
- The counter register and ripple-enable chain stay in the top module.

Test Plan (NDIG=2 unless noted):
1. Count at 0x37, drive rst_n low between edges -> count=0x00 immediately, dec=20'hFFBFE (both banks 10'b1111111110), invalid=0. Release rst_n -> no change until an edge with en=1.
2. load 0x98, then up=1, en=1 for 3 edges -> count 0x99 (tc=1), 0x00 (tc=0), 0x01. Carry ripples into digit 1 only on the 0x?9 -> 0x?0 step (0x08 -> 0x09 -> 0x10).
3. load 0x00, up=0: tc=1. One en edge -> 0x99, tc=0. Next edge -> 0x98.
4. load 0x0C -> invalid=1, dec[9:0]=10'h3FF, dec[19:10]=10'h3FE. One up edge -> 0x00, invalid=0, digit 1 unchanged (no carry).
5. count 0x17, load=1, en=1, up=0, load_val=0x42 -> 0x42 (load wins). Then en=0, load=0 for 5 edges -> stays 0x42.
6. DEC_ACTIVE_LOW=0, load 0x53 -> dec[9:0]=10'h008, dec[19:10]=10'h020. Load 0xF3 -> dec[19:10]=10'h000, invalid=1.
